// File: rtl/conv1d_relu_stream_if.sv
// conv1d_relu_stream_if: sample, coefficient and result bus of the conv1d_relu_stream stage
//   master : upstream/downstream side, drives in_data/in_valid/in_sof, coef_we/coef_addr/coef_data, out_ready
//   slave  : convolution stage, drives in_ready, data_out, data_out_valid
interface conv1d_relu_stream_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int KERNEL_SIZE  = 3,
  parameter int OUT_CHANNELS = 32
);
  localparam int N_COEF     = OUT_CHANNELS * (KERNEL_SIZE + 1);
  localparam int ADDR_WIDTH = N_COEF > 1 ? $clog2(N_COEF) : 1;
  logic signed [DATA_WIDTH-1:0]       in_data;
  logic                               in_valid;
  logic                               in_sof;
  logic                               in_ready;
  logic                               coef_we;
  logic [ADDR_WIDTH-1:0]              coef_addr;
  logic signed [DATA_WIDTH-1:0]       coef_data;
  logic [OUT_CHANNELS*DATA_WIDTH-1:0] data_out;
  logic                               data_out_valid;
  logic                               out_ready;
  modport master (
    output in_data, in_valid, in_sof, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, data_out, data_out_valid
  );
  modport slave (
    input  in_data, in_valid, in_sof, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/conv1d_relu_stream.sv
// conv1d_relu_stream: sliding-window 1-D convolution + ReLU/saturation, one shared MAC over all channels
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears window, coefficients, outputs)
//   bus   : slave side of conv1d_relu_stream_if (sample stream in, coefficient writes, packed result out)
module conv1d_relu_stream #(
  parameter int DATA_WIDTH   = 16,
  parameter int FRAC_BITS    = 8,
  parameter int KERNEL_SIZE  = 3,
  parameter int OUT_CHANNELS = 32,
  parameter int ACC_WIDTH    = 40
) (
  input logic clk,
  input logic rst_n,
  conv1d_relu_stream_if.slave bus
);
  localparam int N_COEF     = OUT_CHANNELS * (KERNEL_SIZE + 1);
  localparam int ADDR_WIDTH = N_COEF > 1 ? $clog2(N_COEF) : 1;
  localparam int CW         = OUT_CHANNELS > 1 ? $clog2(OUT_CHANNELS) : 1;
  localparam int TW         = KERNEL_SIZE > 1 ? $clog2(KERNEL_SIZE) : 1;
  localparam int NW         = $clog2(KERNEL_SIZE + 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t                       state_q, state_d;
  logic                         in_ready_q, in_ready_d;
  logic                         valid_q, valid_d;
  logic [NW-1:0]                count_q, count_d;
  logic [CW-1:0]                c_q, c_d;
  logic [TW-1:0]                t_q, t_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] taps_q [KERNEL_SIZE];
  logic signed [DATA_WIDTH-1:0] taps_d [KERNEL_SIZE];
  logic signed [DATA_WIDTH-1:0] coef_q [N_COEF];
  logic signed [DATA_WIDTH-1:0] coef_d [N_COEF];
  logic [DATA_WIDTH-1:0]        res_q [OUT_CHANNELS];
  logic [DATA_WIDTH-1:0]        res_d [OUT_CHANNELS];
  logic [ADDR_WIDTH-1:0]        w_idx, b_idx;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]  prod_ext, bias_ext, shifted;
  logic                         accept;
  assign accept   = bus.in_valid && in_ready_q;
  assign w_idx    = ADDR_WIDTH'(int'(c_q) * (KERNEL_SIZE + 1) + int'(t_q));
  assign b_idx    = ADDR_WIDTH'(int'(c_q) * (KERNEL_SIZE + 1) + KERNEL_SIZE);
  assign prod     = coef_q[w_idx] * taps_q[t_q];
  assign prod_ext = ACC_WIDTH'(prod);
  // bias is in the same Q format as the samples, so it is aligned to the product scale
  assign bias_ext = ACC_WIDTH'(coef_q[b_idx]) <<< FRAC_BITS;
  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready_q;
    valid_d    = valid_q;
    count_d    = count_q;
    c_d        = c_q;
    t_d        = t_q;
    acc_d      = acc_q;
    taps_d     = taps_q;
    coef_d     = coef_q;
    res_d      = res_q;
    shifted    = '0;
    if (state_q == IDLE && bus.coef_we && 32'(bus.coef_addr) < N_COEF)
      coef_d[bus.coef_addr] = bus.coef_data;
    if (accept) begin
      for (int i = KERNEL_SIZE - 1; i > 0; i--)
        taps_d[i] = bus.in_sof ? '0 : taps_q[i-1];
      taps_d[0] = bus.in_data;
      count_d = bus.in_sof ? NW'(1) : count_q == NW'(KERNEL_SIZE) ? count_q : count_q + 1'b1;
      if (count_d == NW'(KERNEL_SIZE)) begin
        state_d    = MAC;
        in_ready_d = 1'b0;
        c_d        = '0;
        t_d        = '0;
      end
    end
    if (state_q == MAC) begin
      acc_d = (t_q == '0 ? bias_ext : acc_q) + prod_ext;
      if (t_q == TW'(KERNEL_SIZE - 1)) begin
        shifted    = acc_d >>> FRAC_BITS;
        res_d[c_q] = shifted[ACC_WIDTH-1] ? '0 : shifted > SAT_MAX ? SAT_MAX[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
        t_d        = '0;
        c_d        = c_q + 1'b1;
        if (c_q == CW'(OUT_CHANNELS - 1)) begin
          state_d = OUT;
          valid_d = 1'b1;
        end
      end else
        t_d = t_q + 1'b1;
    end
    if (state_q == OUT && bus.out_ready) begin
      state_d    = IDLE;
      valid_d    = 1'b0;
      in_ready_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      count_q    <= '0;
      c_q        <= '0;
      t_q        <= '0;
      acc_q      <= '0;
      taps_q     <= '{default: '0};
      coef_q     <= '{default: '0};
      res_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      count_q    <= count_d;
      c_q        <= c_d;
      t_q        <= t_d;
      acc_q      <= acc_d;
      taps_q     <= taps_d;
      coef_q     <= coef_d;
      res_q      <= res_d;
    end
  end
  assign bus.in_ready       = in_ready_q;
  assign bus.data_out_valid = valid_q;
  for (genvar g = 0; g < OUT_CHANNELS; g++) begin : g_pack
    assign bus.data_out[g*DATA_WIDTH +: DATA_WIDTH] = res_q[g];
  end
endmodule

// File: tb/tb_conv1d_relu_stream.sv
// tb_conv1d_relu_stream: randomized and directed checks of conv1d_relu_stream against an arithmetic model
module tb_conv1d_relu_stream;
  localparam int DW = 16, FB = 8, K = 3, OC = 32, ACW = 40;
  localparam int NC = OC * (K + 1);
  localparam int CAW = $clog2(NC);
  localparam longint SMAX = (longint'(1) << (DW - 1)) - 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  conv1d_relu_stream_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .OUT_CHANNELS(OC)) bus ();
  conv1d_relu_stream #(.DATA_WIDTH(DW), .FRAC_BITS(FB), .KERNEL_SIZE(K), .OUT_CHANNELS(OC), .ACC_WIDTH(ACW))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int mw [NC];
  int win [K];
  int cnt = 0;
  int n_chk = 0;
  int n_fail = 0;
  function automatic void model_clear();
    for (int i = 0; i < NC; i++) mw[i] = 0;
    for (int t = 0; t < K; t++) win[t] = 0;
    cnt = 0;
  endfunction
  function automatic void model_accept(int s, bit sof);
    logic signed [DW-1:0] v;
    v = DW'(s);
    if (sof) begin
      for (int t = 0; t < K; t++) win[t] = 0;
      cnt = 0;
    end
    for (int t = K - 1; t > 0; t--) win[t] = win[t-1];
    win[0] = int'(v);
    cnt = cnt < K ? cnt + 1 : K;
  endfunction
  function automatic logic [OC*DW-1:0] exp_vec();
    logic [OC*DW-1:0] v;
    longint acc;
    v = '0;
    for (int c = 0; c < OC; c++) begin
      acc = longint'(mw[c*(K+1)+K]) * (longint'(1) << FB);
      for (int t = 0; t < K; t++) acc += longint'(mw[c*(K+1)+t]) * longint'(win[t]);
      acc = acc >>> FB;
      v[c*DW +: DW] = acc < 0 ? '0 : acc > SMAX ? DW'(SMAX) : DW'(acc);
    end
    return v;
  endfunction
  task automatic write_coef(int a, int d);
    logic signed [DW-1:0] v;
    v = DW'(d);
    @(negedge clk);
    bus.coef_we = 1'b1;
    bus.coef_addr = CAW'(a);
    bus.coef_data = v;
    mw[a] = int'(v);
    @(negedge clk);
    bus.coef_we = 1'b0;
  endtask
  task automatic set_all(int w, int b);
    for (int c = 0; c < OC; c++) begin
      for (int t = 0; t < K; t++) write_coef(c*(K+1)+t, w);
      write_coef(c*(K+1)+K, b);
    end
  endtask
  task automatic send(int s, bit sof);
    int k;
    k = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = DW'(s);
    bus.in_sof = sof;
    while (!bus.in_ready && k < 400) begin @(negedge clk); k++; end
    if (!bus.in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout in_ready=%b required 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    model_accept(s, sof);
  endtask
  task automatic wait_result(input int start, output logic [OC*DW-1:0] got, output int lat);
    int n;
    n = start;
    while (!bus.data_out_valid && n < 400) begin @(negedge clk); n++; end
    lat = bus.data_out_valid ? n - 1 : -1;
    got = bus.data_out;
  endtask
  task automatic pop();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask
  task automatic idle_watch(int n, output bit busy);
    busy = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (bus.data_out_valid || !bus.in_ready) busy = 1'b1;
    end
  endtask
  task automatic test_reset();
    logic [OC*DW-1:0] got;
    int lat;
    repeat (2) @(negedge clk);
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.data_out_valid !== 1'b0 || bus.data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_values in_ready=%b valid=%b data_out=%h required 1/0/0", bus.in_ready, bus.data_out_valid, bus.data_out);
    end
    rst_n = 1'b1;
    set_all(16'h0100, 16'h0040);
    send(16'h0100, 1'b1);
    send(16'h0200, 1'b0);
    send(16'h0300, 1'b0);
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.data_out_valid !== 1'b0 || bus.data_out !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_mac in_ready=%b valid=%b data_out=%h required 1/0/0", bus.in_ready, bus.data_out_valid, bus.data_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    send(16'h0500, 1'b0);
    send(16'h0600, 1'b0);
    send(16'h0700, 1'b0);
    wait_result(1, got, lat);
    n_chk++;
    if (lat !== OC*K || got !== '0) begin
      n_fail++;
      $display("FAIL reset_coef_cleared latency=%0d data_out=%h required %0d/0", lat, got, OC*K);
    end
    pop();
  endtask
  task automatic test_basic();
    logic [OC*DW-1:0] got;
    int lat;
    bit busy;
    set_all(16'h0100, 0);
    send(16'h0100, 1'b1);
    idle_watch(4, busy);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_quiet_1 busy=%b required 0", busy); end
    send(16'h0200, 1'b0);
    idle_watch(4, busy);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_quiet_2 busy=%b required 0", busy); end
    send(16'h0300, 1'b0);
    wait_result(1, got, lat);
    n_chk++;
    if (lat !== OC*K) begin n_fail++; $display("FAIL basic_latency got=%0d required %0d", lat, OC*K); end
    n_chk++;
    if (got !== {OC{16'h0600}}) begin n_fail++; $display("FAIL basic_0600 got=%h required all 0600", got); end
    pop();
    send(16'h0400, 1'b0);
    wait_result(1, got, lat);
    n_chk++;
    if (got !== {OC{16'h0900}} || got !== exp_vec()) begin
      n_fail++; $display("FAIL basic_0900 got=%h required all 0900", got);
    end
    pop();
  endtask
  task automatic test_relu_bias();
    logic [OC*DW-1:0] got;
    int lat;
    for (int t = 0; t < K; t++) write_coef(t, 16'hFF00);
    write_coef(K, 0);
    for (int t = 0; t < K; t++) write_coef((K+1)+t, 0);
    write_coef((K+1)+K, 16'h0280);
    send(16'h0100, 1'b1);
    send(16'h0100, 1'b0);
    send(16'h0100, 1'b0);
    wait_result(1, got, lat);
    n_chk++;
    if (got[0 +: DW] !== 16'h0000 || got[DW +: DW] !== 16'h0280) begin
      n_fail++; $display("FAIL relu_bias ch0=%h ch1=%h required 0000/0280", got[0 +: DW], got[DW +: DW]);
    end
    n_chk++;
    if (got !== exp_vec()) begin n_fail++; $display("FAIL relu_bias_vec got=%h required %h", got, exp_vec()); end
    pop();
  endtask
  task automatic test_saturation();
    logic [OC*DW-1:0] got;
    int lat;
    set_all(16'h7FFF, 0);
    for (int i = 0; i < K; i++) send(16'h7FFF, i == 0);
    wait_result(1, got, lat);
    n_chk++;
    if (got !== {OC{16'h7FFF}}) begin n_fail++; $display("FAIL sat_pos got=%h required all 7fff", got); end
    pop();
    set_all(16'h8000, 0);
    for (int i = 0; i < K; i++) send(16'h7FFF, i == 0);
    wait_result(1, got, lat);
    n_chk++;
    if (got !== '0) begin n_fail++; $display("FAIL sat_neg got=%h required 0", got); end
    pop();
  endtask
  task automatic test_backpressure();
    logic [OC*DW-1:0] got, held;
    int lat, s;
    bit moved, rdy, vld;
    set_all(16'h0100, 16'h0010);
    for (int i = 0; i < K; i++) send(int'($urandom_range(0, 2047)) - 1024, i == 0);
    wait_result(1, held, lat);
    s = int'($urandom_range(0, 2047)) - 1024;
    bus.in_valid = 1'b1;
    bus.in_data = DW'(s);
    moved = 1'b0; rdy = 1'b0; vld = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (bus.data_out !== held) moved = 1'b1;
      if (bus.in_ready !== 1'b0) rdy = 1'b1;
      if (bus.data_out_valid !== 1'b1) vld = 1'b0;
    end
    n_chk++;
    if (moved || !vld) begin n_fail++; $display("FAIL bp_hold moved=%b valid=%b required 0/1", moved, vld); end
    n_chk++;
    if (rdy) begin n_fail++; $display("FAIL bp_in_ready saw in_ready=1 required 0"); end
    pop();
    n_chk++;
    if (bus.in_ready !== 1'b1 || bus.data_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release in_ready=%b valid=%b required 1/0", bus.in_ready, bus.data_out_valid);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    model_accept(s, 1'b0);
    wait_result(1, got, lat);
    n_chk++;
    if (lat !== OC*K || got !== exp_vec()) begin
      n_fail++; $display("FAIL bp_next latency=%0d got=%h required %0d/%h", lat, got, OC*K, exp_vec());
    end
    pop();
  endtask
  task automatic test_frame_restart();
    logic [OC*DW-1:0] got;
    int lat;
    bit busy;
    for (int i = 0; i < NC; i++) write_coef(i, int'($urandom_range(0, 1023)) - 512);
    send(int'($urandom_range(0, 2047)) - 1024, 1'b1);
    idle_watch(4, busy);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_quiet_1 busy=%b required 0", busy); end
    send(int'($urandom_range(0, 2047)) - 1024, 1'b0);
    idle_watch(4, busy);
    n_chk++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_quiet_2 busy=%b required 0", busy); end
    send(int'($urandom_range(0, 2047)) - 1024, 1'b0);
    repeat (6) begin
      bus.coef_we = 1'b1;
      bus.coef_addr = CAW'($urandom_range(0, NC - 1));
      bus.coef_data = DW'($urandom);
      @(negedge clk);
    end
    bus.coef_we = 1'b0;
    wait_result(7, got, lat);
    n_chk++;
    if (lat !== OC*K || got !== exp_vec()) begin
      n_fail++; $display("FAIL restart_result latency=%0d got=%h required %0d/%h", lat, got, OC*K, exp_vec());
    end
    pop();
  endtask
  task automatic test_random();
    logic [OC*DW-1:0] got;
    int lat;
    bit busy;
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 2) == 0)
        write_coef(int'($urandom_range(0, NC - 1)), int'($urandom_range(0, 1023)) - 512);
      send(int'($urandom_range(0, 4095)) - 2048, $urandom_range(0, 3) == 0);
      if (cnt == K) begin
        wait_result(1, got, lat);
        n_chk++;
        if (lat !== OC*K || got !== exp_vec()) begin
          n_fail++; $display("FAIL random_%0d latency=%0d got=%h required %0d/%h", it, lat, got, OC*K, exp_vec());
        end
        pop();
      end else begin
        idle_watch(3, busy);
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL random_quiet_%0d busy=%b required 0", it, busy); end
      end
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_data = '0;
    bus.coef_we = 1'b0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    bus.out_ready = 1'b0;
    model_clear();
    test_reset();
    test_basic();
    test_relu_bias();
    test_saturation();
    test_backpressure();
    test_frame_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
